inst_fetch_cond: RTL and testbench

Instruction-fetch and condition-check stage directly upstream of the data-processing CPU control FSM.
- Holds PC (word address) and IR, and fetches 32-bit words from instruction memory over a req/ready handshake with variable latency.
- Splits the fetched word into condition_code and IR[27:0].
- Evaluates the condition against the NZCV supplied by the ALU stage and drives flag.
- The control FSM pulses Write_IR/Write_PC, waits for IR_valid, then reads flag.

---
 rtl/inst_fetch_cond.sv | 136 +++++++++++++
 tb/tb_inst_fetch_cond.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_cond.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_cond
// Description : Instruction fetch (PC/IR, req/ready memory handshake with
//               timeout) and ARM-style condition evaluation against NZCV.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_cond #(
    parameter int          AW       = 6,
    parameter int          MAX_WAIT = 15,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          Write_IR,
    input  logic          Write_PC,
    input  logic          PC_load,
    input  logic [AW-1:0] PC_new,
    input  logic [3:0]    NZCV,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata,
    output logic [AW-1:0] Inst_addr,
    output logic [3:0]    condition_code,
    output logic [27:0]   IR,
    output logic          IR_valid,
    output logic          flag,
    output logic          fetch_err
);

    localparam int c_CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT = c_CNT_W'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_pc;
    logic [31:0]          r_ir_full;
    logic                 r_ir_valid;
    logic                 r_mem_req;
    logic [AW-1:0]        r_mem_addr;
    logic                 r_fetch_err;
    logic [c_CNT_W-1:0]   r_wait_cnt;

    // PC update runs independently of the fetch FSM; a redirect wins over increment.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_pc <= '0;
        end else if (PC_load) begin
            r_pc <= PC_new;
        end else if (Write_PC) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= S_IDLE;
            r_ir_full   <= '0;
            r_ir_valid  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_fetch_err <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Write_IR) begin
                        r_mem_addr <= r_pc;
                        r_mem_req  <= 1'b1;
                        r_ir_valid <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_ir_full  <= mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_wait_cnt == c_LAST_WAIT) begin
                        // Timed out: substitute a harmless NOP so the control FSM can proceed.
                        r_ir_full   <= NOP_WORD;
                        r_ir_valid  <= 1'b1;
                        r_fetch_err <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = NZCV;

    always_comb begin
        flag = 1'b0;
        case (r_ir_full[31:28])
            4'b0000: flag = w_z;
            4'b0001: flag = ~w_z;
            4'b0010: flag = w_c;
            4'b0011: flag = ~w_c;
            4'b0100: flag = w_n;
            4'b0101: flag = ~w_n;
            4'b0110: flag = w_v;
            4'b0111: flag = ~w_v;
            4'b1000: flag = w_c & ~w_z;
            4'b1001: flag = ~w_c | w_z;
            4'b1010: flag = (w_n == w_v);
            4'b1011: flag = (w_n != w_v);
            4'b1100: flag = ~w_z & (w_n == w_v);
            4'b1101: flag = w_z | (w_n != w_v);
            4'b1110: flag = 1'b1;
            default: flag = 1'b0;
        endcase
    end

    assign mem_req        = r_mem_req;
    assign mem_addr       = r_mem_addr;
    assign Inst_addr      = r_pc;
    assign condition_code = r_ir_full[31:28];
    assign IR             = r_ir_full[27:0];
    assign IR_valid       = r_ir_valid;
    assign fetch_err      = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_cond
// Description : Directed self-checking bench for inst_fetch_cond.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_fetch_cond;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          Rst;
    logic          Write_IR, Write_PC, PC_load;
    logic [AW-1:0] PC_new;
    logic [3:0]    NZCV;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [AW-1:0] Inst_addr;
    logic [3:0]    condition_code;
    logic [27:0]   IR;
    logic          IR_valid, flag, fetch_err;

    int checks   = 0;
    int failures = 0;

    inst_fetch_cond #(.AW(AW), .MAX_WAIT(15), .NOP_WORD(32'hE1A00000)) dut (
        .clk(clk), .Rst(Rst), .Write_IR(Write_IR), .Write_PC(Write_PC),
        .PC_load(PC_load), .PC_new(PC_new), .NZCV(NZCV),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .Inst_addr(Inst_addr),
        .condition_code(condition_code), .IR(IR), .IR_valid(IR_valid),
        .flag(flag), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference condition table written from the architectural definition.
    function automatic logic ref_flag(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    task automatic do_fetch(input logic [31:0] word);
        Write_IR = 1'b1;
        tick();
        Write_IR  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = word;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Write_IR = 0; Write_PC = 0; PC_load = 0; PC_new = '0;
        NZCV = '0; mem_ready = 0; mem_rdata = '0;
        tick(); tick();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 6'd0 || Inst_addr !== 6'd0 ||
            IR_valid !== 1'b0 || fetch_err !== 1'b0 || IR !== 28'd0 || condition_code !== 4'd0) begin
            failures++;
            $display("FAIL reset: req=%b addr=%0d pc=%0d valid=%b err=%b ir=%h cc=%h, want all zero",
                     mem_req, mem_addr, Inst_addr, IR_valid, fetch_err, IR, condition_code);
        end
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_fetch();
        Write_IR = 1'b1; Write_PC = 1'b1;
        tick();
        Write_IR = 1'b0; Write_PC = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 6'd0 || Inst_addr !== 6'd1 || IR_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_issue: req=%b addr=%0d pc=%0d valid=%b, want 1 0 1 0",
                     mem_req, mem_addr, Inst_addr, IR_valid);
        end
        mem_ready = 1'b1; mem_rdata = 32'hE0812003;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (IR_valid !== 1'b1 || condition_code !== 4'hE || IR !== 28'h0812003 ||
            flag !== 1'b1 || mem_req !== 1'b0 || Inst_addr !== 6'd1) begin
            failures++;
            $display("FAIL basic_load: valid=%b cc=%h ir=%h flag=%b req=%b pc=%0d, want 1 e 0812003 1 0 1",
                     IR_valid, condition_code, IR, flag, mem_req, Inst_addr);
        end
    endtask

    task automatic test_delayed_ready();
        Write_IR = 1'b1;
        tick();
        Write_IR = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 6'd1 || IR_valid !== 1'b0) begin
                failures++;
                $display("FAIL delayed_wait%0d: req=%b addr=%0d valid=%b, want 1 1 0",
                         i, mem_req, mem_addr, IR_valid);
            end
            Write_IR  = (i == 2);
            mem_ready = (i == 5);
            mem_rdata = (i == 5) ? 32'h0ABCDEF1 : 32'hFFFFFFFF;
            tick();
        end
        Write_IR = 1'b0; mem_ready = 1'b0;
        checks++;
        if (IR_valid !== 1'b1 || condition_code !== 4'h0 || IR !== 28'hABCDEF1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL delayed_load: valid=%b cc=%h ir=%h req=%b, want 1 0 abcdef1 0",
                     IR_valid, condition_code, IR, mem_req);
        end
        tick();
        checks++;
        if (IR_valid !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL delayed_ignore_pulse: valid=%b req=%b, want 1 0", IR_valid, mem_req);
        end
    endtask

    task automatic test_flags();
        do_fetch(32'h00000000);
        NZCV = 4'b0100; #1;
        checks++;
        if (flag !== 1'b1) begin
            failures++;
            $display("FAIL flag_eq_zset: flag=%b, want 1", flag);
        end
        NZCV = 4'b0000; #1;
        checks++;
        if (flag !== 1'b0) begin
            failures++;
            $display("FAIL flag_eq_zclr: flag=%b, want 0", flag);
        end
        for (int cc = 0; cc < 16; cc++) begin
            logic [3:0] cc4;
            cc4 = 4'(cc);
            do_fetch({cc4, 28'h1234567});
            for (int f = 0; f < 16; f++) begin
                NZCV = 4'(f); #1;
                checks++;
                if (flag !== ref_flag(cc4, 4'(f))) begin
                    failures++;
                    $display("FAIL flag_sweep cc=%h nzcv=%b: flag=%b, want %b",
                             cc4, 4'(f), flag, ref_flag(cc4, 4'(f)));
                end
            end
        end
    endtask

    task automatic test_pc_update();
        PC_load = 1'b1; PC_new = 6'd63;
        tick();
        PC_load = 1'b0; Write_PC = 1'b1;
        tick();
        Write_PC = 1'b0;
        checks++;
        if (Inst_addr !== 6'd0) begin
            failures++;
            $display("FAIL pc_wrap: pc=%0d, want 0", Inst_addr);
        end
        PC_load = 1'b1; PC_new = 6'd20; Write_PC = 1'b1;
        tick();
        PC_load = 1'b0; Write_PC = 1'b0;
        checks++;
        if (Inst_addr !== 6'd20) begin
            failures++;
            $display("FAIL pc_load_priority: pc=%0d, want 20", Inst_addr);
        end
    endtask

    task automatic test_timeout();
        Write_IR = 1'b1;
        tick();
        Write_IR = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        checks++;
        if (IR_valid !== 1'b0 || mem_req !== 1'b1 || fetch_err !== 1'b0 || mem_addr !== 6'd20) begin
            failures++;
            $display("FAIL timeout_edge14: valid=%b req=%b err=%b addr=%0d, want 0 1 0 20",
                     IR_valid, mem_req, fetch_err, mem_addr);
        end
        tick();
        checks++;
        if (IR_valid !== 1'b1 || fetch_err !== 1'b1 || mem_req !== 1'b0 ||
            condition_code !== 4'hE || IR !== 28'h1A00000) begin
            failures++;
            $display("FAIL timeout_nop: valid=%b err=%b req=%b cc=%h ir=%h, want 1 1 0 e 1a00000",
                     IR_valid, fetch_err, mem_req, condition_code, IR);
        end
        do_fetch(32'hE0000001);
        checks++;
        if (fetch_err !== 1'b1 || IR !== 28'h0000001) begin
            failures++;
            $display("FAIL fetch_err_sticky: err=%b ir=%h, want 1 0000001", fetch_err, IR);
        end
    endtask

    task automatic test_reset_mid_wait();
        Write_IR = 1'b1;
        tick();
        Write_IR = 1'b0;
        tick(); tick();
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || IR_valid !== 1'b0 || Inst_addr !== 6'd0 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: req=%b valid=%b pc=%0d err=%b, want 0 0 0 0",
                     mem_req, IR_valid, Inst_addr, fetch_err);
        end
        tick();
        Rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h5FFFFFFF;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (IR_valid !== 1'b0 || IR !== 28'd0 || condition_code !== 4'd0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_late_ready: valid=%b ir=%h cc=%h req=%b, want 0 0 0 0",
                     IR_valid, IR, condition_code, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_delayed_ready();
        test_flags();
        test_pc_update();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
